// File: rtl/btn_pkg.sv
// Shared constants and width helpers for the push-button conditioner.
package btn_pkg;

  // Defaults for a 100 MHz board clock
  localparam int unsigned BTN_STABLE_DEF = 500000;
  localparam int unsigned BTN_HOLD_DEF   = 25000000;
  localparam int unsigned BTN_REPEAT_DEF = 5000000;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;
  localparam int unsigned BTN_RST   = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold n-1, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// Single-bit button conditioner: synchroniser, stability counter, strobes.
// Auto-repeat logic is generated only when BTN_REPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = BTN_STABLE_DEF,
  parameter bit          IN_ACT_LOW    = 1'b0
`ifdef BTN_REPEAT_EN
  , parameter int unsigned HOLD_CYCLES   = BTN_HOLD_DEF
  , parameter int unsigned REPEAT_CYCLES = BTN_REPEAT_DEF
`endif
) (
  input  logic clk,
  input  logic clr_n,
  input  logic raw,
  output logic level,
  output logic press,
  output logic rel
);

  localparam int unsigned CW = cnt_w(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  logic          raw_in;
  logic          s1;
  logic          s2;
  logic          stable;
  logic [CW-1:0] cnt;
  logic          flip;
  logic          rep_fire;

  assign raw_in = IN_ACT_LOW ? ~raw : raw;
  assign flip   = (s2 != stable) && (cnt == CNT_LAST);

`ifdef BTN_REPEAT_EN
  localparam int unsigned RW = cnt_w(max_u(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [RW-1:0] HOLD_LAST = RW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] REP_LAST  = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rcnt;
  logic          first;
  logic [RW-1:0] rep_last;

  assign rep_last = first ? HOLD_LAST : REP_LAST;
  // A flip edge always wins, so a repeat can never land on a release
  assign rep_fire = stable && !flip && (rcnt == rep_last);

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      rcnt  <= '0;
      first <= 1'b1;
    end else if (!stable || flip) begin
      rcnt  <= '0;
      first <= 1'b1;
    end else if (rep_fire) begin
      rcnt  <= '0;
      first <= 1'b0;
    end else begin
      rcnt <= rcnt + RW'(1);
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // Debounce: any agreeing cycle restarts qualification
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
      rel    <= 1'b0;
    end else begin
      s1    <= raw_in;
      s2    <= s1;
      press <= rep_fire;
      rel   <= 1'b0;
      if (s2 == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= s2;
        cnt    <= '0;
        press  <= s2;
        rel    <= ~s2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign level = stable;

endmodule

// File: rtl/btn_debounce.sv
// Multi-channel push-button conditioner; one independent btn_debounce_ch per pin.
// Optional auto-repeat on held buttons is enabled by defining BTN_REPEAT_EN.
module btn_debounce
  import btn_pkg::*;
#(
  parameter int unsigned N_CH          = 5,
  parameter int unsigned STABLE_CYCLES = BTN_STABLE_DEF,
  parameter bit          IN_ACT_LOW    = 1'b0,
  parameter int unsigned HOLD_CYCLES   = BTN_HOLD_DEF,
  parameter int unsigned REPEAT_CYCLES = BTN_REPEAT_DEF
) (
  input  logic            clk,
  input  logic            clr_n,
  input  logic [N_CH-1:0] in_button,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release
);

  if (STABLE_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("btn_debounce: illegal cycle-count parameter");
  end

  for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .IN_ACT_LOW   (IN_ACT_LOW)
`ifdef BTN_REPEAT_EN
      , .HOLD_CYCLES  (HOLD_CYCLES)
      , .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
    ) u_ch (
      .clk  (clk),
      .clr_n(clr_n),
      .raw  (in_button[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel  (btn_release[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce.sv
// Scoreboard bench for btn_debounce with STABLE=4, HOLD=10, REPEAT=3, five channels.
module tb_btn_debounce;

  localparam int N_CH   = 5;
  localparam int STABLE = 4;
  localparam int HOLD   = 10;
  localparam int REP    = 3;

  logic            clk = 1'b0;
  logic            clr_n = 1'b0;
  logic [N_CH-1:0] in_button = '0;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_press;
  logic [N_CH-1:0] btn_release;

  int edge_n = 0;
  int n_cmp  = 0;
  int n_bad  = 0;

  typedef struct {
    int at;
    int ch;
    bit is_press;
  } ev_t;

  ev_t sb[$];

  btn_debounce #(
    .N_CH         (N_CH),
    .STABLE_CYCLES(STABLE),
    .IN_ACT_LOW   (1'b0),
    .HOLD_CYCLES  (HOLD),
    .REPEAT_CYCLES(REP)
  ) dut (
    .clk        (clk),
    .clr_n      (clr_n),
    .in_button  (in_button),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, got, exp);
    end
  endtask

  // Expected strobes for one hold: press, repeats while stable, then release
  task automatic exp_hold(input int ch, input int p, input int r);
    sb.push_back('{p, ch, 1'b1});
`ifdef BTN_REPEAT_EN
    for (int e = p + HOLD; e < r; e += REP) sb.push_back('{e, ch, 1'b1});
`endif
    sb.push_back('{r, ch, 1'b0});
  endtask

  task automatic wait_to(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  function automatic int find_ev(input int at, input int ch, input bit is_press);
    for (int k = 0; k < sb.size(); k++)
      if (sb[k].at == at && sb[k].ch == ch && sb[k].is_press == is_press) return k;
    return -1;
  endfunction

  // Monitor: every strobe must match a queued expectation at its edge
  always @(negedge clk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (btn_press[i] && btn_release[i]) begin
        n_cmp++;
        n_bad++;
        $display("FAIL excl ch%0d @edge %0d: got press+release expected one", i, edge_n);
      end else if (btn_press[i] || btn_release[i]) begin
        int idx;
        idx = find_ev(edge_n, i, btn_press[i]);
        n_cmp++;
        if (idx < 0) begin
          n_bad++;
          $display("FAIL strobe ch%0d @edge %0d: got %s expected none", i, edge_n,
                   btn_press[i] ? "press" : "release");
        end else begin
          sb.delete(idx);
          chk($sformatf("level_at_strobe ch%0d", i), 32'(btn_level[i]), 32'(btn_press[i]));
        end
      end
    end
    for (int k = sb.size() - 1; k >= 0; k--) begin
      if (sb[k].at < edge_n) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed ch%0d: got none expected %s @edge %0d", sb[k].ch,
                 sb[k].is_press ? "press" : "release", sb[k].at);
        sb.delete(k);
      end
    end
  end

  initial begin
    for (int e = 1; e <= 3; e++) begin
      wait_to(e);
      chk("reset_level", 32'(btn_level), 32'd0);
      chk("reset_press", 32'(btn_press), 32'd0);
      chk("reset_release", 32'(btn_release), 32'd0);
    end
    clr_n = 1'b1;

    // Clean press on ch0
    wait_to(5);
    in_button[0] = 1'b1;
    exp_hold(0, 11, 60);
    wait_to(10); chk("clean_level_pre", 32'(btn_level), 32'd0);
    wait_to(11); chk("clean_level", 32'(btn_level), 32'h01);

    // Bounce on ch1, last transition at 32
    for (int e = 20; e <= 32; e += 2) begin
      wait_to(e);
      in_button[1] = ((e - 20) % 4 == 0);
    end
    exp_hold(1, 38, 76);
    wait_to(37); chk("bounce_level_pre", 32'(btn_level[1]), 32'd0);
    wait_to(38); chk("bounce_level", 32'(btn_level[1]), 32'd1);

    // Three-cycle glitch on ch2; ch3 pressed meanwhile
    wait_to(40);
    in_button[2] = 1'b1;
    for (int e = 41; e <= 53; e++) begin
      wait_to(e);
      if (e == 43) in_button[2] = 1'b0;
      if (e == 44) begin
        in_button[3] = 1'b1;
        exp_hold(3, 50, 60);
      end
      chk("glitch_level", 32'(btn_level[2]), 32'd0);
    end

    // Simultaneous release of ch0 and ch3
    wait_to(54);
    in_button[0] = 1'b0;
    in_button[3] = 1'b0;
    wait_to(59); chk("rel_level_pre", 32'(btn_level & 5'b01001), 32'h09);
    wait_to(60); chk("rel_level", 32'(btn_level & 5'b01001), 32'h00);

    wait_to(70); in_button[1] = 1'b0;
    wait_to(76); chk("rel1_level", 32'(btn_level[1]), 32'd0);

    // Reset while ch4 counter sits at 2
    wait_to(80);
    in_button[4] = 1'b1;
    exp_hold(4, 91, 146);
    wait_to(84); clr_n = 1'b0;
    wait_to(85);
    clr_n = 1'b1;
    chk("midrst_level", 32'(btn_level), 32'd0);
    chk("midrst_press", 32'(btn_press), 32'd0);
    wait_to(90); chk("midrst_level_pre", 32'(btn_level[4]), 32'd0);
    wait_to(91); chk("midrst_level_post", 32'(btn_level[4]), 32'd1);

    // Long hold on ch0 for the auto-repeat case
    wait_to(100);
    in_button[0] = 1'b1;
    exp_hold(0, 106, 136);
    wait_to(130); in_button[0] = 1'b0;
    wait_to(136); chk("hold_rel_level", 32'(btn_level[0]), 32'd0);
    wait_to(140); in_button[4] = 1'b0;
    wait_to(146); chk("ch4_rel_level", 32'(btn_level[4]), 32'd0);

    wait_to(160);
    chk("final_level", 32'(btn_level), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
